// File: rtl/rtc_bus_escritura.sv
// RTC multiplexed-bus sequencer: address phase then data phase, each with counted setup/strobe/hold.
// Outputs are registered from the next state, so they line up with the state register.
module rtc_bus_escritura #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rd_wr,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dato_leido,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN
  } state_t;

  localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d, phase_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_end;
  logic [7:0]       dir_q, dir_d, dato_q, dato_d;
  logic             rd_wr_q, rd_wr_d;
  logic [7:0]       bus_out_q, bus_out_d, dato_leido_q, dato_leido_d;
  logic             bus_oe_q, bus_oe_d, cs_n_q, cs_n_d, ad_q, ad_d;
  logic             wr_n_q, wr_n_d, rd_n_q, rd_n_d, busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= '0;
      dato_q       <= '0;
      rd_wr_q      <= 1'b0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      cs_n_q       <= 1'b1;
      ad_q         <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      dato_leido_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      dato_q       <= dato_d;
      rd_wr_q      <= rd_wr_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
      cs_n_q       <= cs_n_d;
      ad_q         <= ad_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
      dato_leido_q <= dato_leido_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    dato_d    = dato_q;
    rd_wr_d   = rd_wr_q;
    phase_end = 1'b0;
    phase_nxt = IDLE;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = A_SET;
          cnt_d   = '0;
          dir_d   = dir;
          dato_d  = dato;
          rd_wr_d = rd_wr;
        end
      end
      A_SET: begin phase_end = (cnt_q == SET_LAST);   phase_nxt = A_STB; end
      A_STB: begin phase_end = (cnt_q == PULSE_LAST); phase_nxt = A_HLD; end
      A_HLD: begin phase_end = (cnt_q == HOLD_LAST);  phase_nxt = D_SET; end
      D_SET: begin phase_end = (cnt_q == SET_LAST);   phase_nxt = D_STB; end
      D_STB: begin phase_end = (cnt_q == PULSE_LAST); phase_nxt = D_HLD; end
      D_HLD: begin phase_end = (cnt_q == HOLD_LAST);  phase_nxt = FIN;   end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Timed phases share one counter that restarts at every phase boundary.
    if (state_q != IDLE && state_q != FIN) begin
      if (phase_end) begin
        state_d = phase_nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin : outputs
    bus_out_d    = '0;
    bus_oe_d     = 1'b0;
    cs_n_d       = 1'b1;
    ad_d         = 1'b1;
    wr_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
    dato_leido_d = dato_leido_q;
    unique case (state_d)
      A_SET, A_STB, A_HLD: begin
        cs_n_d    = 1'b0;
        ad_d      = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = dir_d;
        wr_n_d    = (state_d != A_STB);
      end
      D_SET, D_STB, D_HLD: begin
        cs_n_d = 1'b0;
        if (rd_wr_d) begin
          bus_oe_d  = 1'b1;
          bus_out_d = dato_d;
          wr_n_d    = (state_d != D_STB);
        end else begin
          rd_n_d = (state_d != D_STB);
        end
      end
      default: ;
    endcase
    // Sample the RTC as late as possible in the read strobe.
    if (state_q == D_STB && cnt_q == PULSE_LAST && !rd_wr_q)
      dato_leido_d = bus_in;
  end

  assign bus_out    = bus_out_q;
  assign bus_oe     = bus_oe_q;
  assign cs_n       = cs_n_q;
  assign ad         = ad_q;
  assign wr_n       = wr_n_q;
  assign rd_n       = rd_n_q;
  assign dato_leido = dato_leido_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rtc_bus_escritura.sv
// Scoreboard bench: stimulus queues expected transactions, a bus monitor reconstructs each
// transaction from the pins and compares on done. Two instances: default timing and 1/1/1.
module tb_rtc_bus_escritura;

  localparam int S0 = 2, P0 = 4, H0 = 2;
  localparam int S1 = 1, P1 = 1, H1 = 1;

  logic       clk = 1'b0;
  logic       rst_n, start, rd_wr, sel;
  logic [7:0] dir, dato, bus_in;
  logic       start0, start1;
  logic [7:0] bus_out0, bus_out1, dl0, dl1;
  logic       oe0, oe1, cs0, cs1, ad0, ad1, wr0, wr1, rd0, rd1, busy0, busy1, done0, done1;
  logic [7:0] m_bus_out, m_dl;
  logic       m_oe, m_cs_n, m_ad, m_wr_n, m_rd_n, m_busy, m_done;

  assign start0    = start & ~sel;
  assign start1    = start & sel;
  assign m_bus_out = sel ? bus_out1 : bus_out0;
  assign m_dl      = sel ? dl1 : dl0;
  assign m_oe      = sel ? oe1 : oe0;
  assign m_cs_n    = sel ? cs1 : cs0;
  assign m_ad      = sel ? ad1 : ad0;
  assign m_wr_n    = sel ? wr1 : wr0;
  assign m_rd_n    = sel ? rd1 : rd0;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_done    = sel ? done1 : done0;

  rtc_bus_escritura #(.T_SETUP(S0), .T_PULSE(P0), .T_HOLD(H0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rd_wr(rd_wr), .dir(dir), .dato(dato),
    .bus_in(bus_in), .bus_out(bus_out0), .bus_oe(oe0), .cs_n(cs0), .ad(ad0), .wr_n(wr0),
    .rd_n(rd0), .dato_leido(dl0), .busy(busy0), .done(done0));

  rtc_bus_escritura #(.T_SETUP(S1), .T_PULSE(P1), .T_HOLD(H1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_wr(rd_wr), .dir(dir), .dato(dato),
    .bus_in(bus_in), .bus_out(bus_out1), .bus_oe(oe1), .cs_n(cs1), .ad(ad1), .wr_n(wr1),
    .rd_n(rd1), .dato_leido(dl1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] dir, dato, rdata;
    int         setup, pulse, phase, lat, gap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0, checks = 0, dones = 0, pushed = 0, tick = 0, last_done = 0;
  logic [7:0] last_rd[2];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference: a transaction is fully described by its operands and the three phase widths.
  task automatic push_exp(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] bi, input int gap);
    exp_t e;
    int s, p, h;
    s = sel ? S1 : S0;
    p = sel ? P1 : P0;
    h = sel ? H1 : H0;
    e.wr    = w;
    e.dir   = a;
    e.dato  = d;
    e.rdata = w ? last_rd[sel] : bi;
    last_rd[sel] = e.rdata;
    e.setup = s;
    e.pulse = p;
    e.phase = s + p + h;
    e.lat   = 2 * (s + p + h);
    e.gap   = gap;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Monitor: rebuilds each transaction from the pins.
  logic       trk = 1'b0, p_busy = 1'b0, p_wr, p_rd, p_ad;
  logic [7:0] p_bo, a_byte, d_byte;
  int         cyc, a_cyc, d_cyc, a_wr, d_wr, rd_cnt, d_oe, a_fall, d_fall, viol;

  always @(negedge clk) begin
    tick++;
    if (!rst_n) begin
      trk    = 1'b0;
      p_busy = 1'b0;
    end else begin
      if (m_busy && !p_busy) begin
        trk = 1'b1; cyc = 0; a_cyc = 0; d_cyc = 0; a_wr = 0; d_wr = 0; rd_cnt = 0;
        d_oe = 0; a_fall = -1; d_fall = -1; viol = 0; a_byte = m_bus_out; d_byte = 8'h00;
      end else if (trk) begin
        cyc++;
      end
      if (trk) begin
        if (!m_wr_n && !m_rd_n) viol++;
        if ((!m_wr_n || !m_rd_n) && m_cs_n) viol++;
        if (cyc > 0 && (m_wr_n != p_wr || m_rd_n != p_rd) && (m_ad != p_ad || m_bus_out != p_bo))
          viol++;
        if (!m_cs_n && !m_ad) begin
          if (!m_oe || m_bus_out != a_byte || !m_rd_n) viol++;
          if (!m_wr_n) begin
            if (a_wr == 0) a_fall = a_cyc;
            a_wr++;
          end
          a_cyc++;
        end else if (!m_cs_n) begin
          if (m_oe) begin
            if (d_oe == 0) d_byte = m_bus_out;
            else if (m_bus_out != d_byte) viol++;
            d_oe++;
          end else if (m_bus_out != 8'h00) begin
            viol++;
          end
          if ((!m_wr_n || !m_rd_n) && (d_wr + rd_cnt == 0)) d_fall = d_cyc;
          if (!m_wr_n) d_wr++;
          if (!m_rd_n) rd_cnt++;
          d_cyc++;
        end
      end
      if (m_done) begin
        dones++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: done seen at tick %0d, required no transaction pending", tick);
        end else begin
          mon_e = exp_q.pop_front();
          check("addr_byte", int'(a_byte), int'(mon_e.dir));
          check("addr_cycles", a_cyc, mon_e.phase);
          check("addr_setup", a_fall, mon_e.setup);
          check("addr_wr_pulse", a_wr, mon_e.pulse);
          check("data_cycles", d_cyc, mon_e.phase);
          check("data_setup", d_fall, mon_e.setup);
          check("data_wr_pulse", d_wr, mon_e.wr ? mon_e.pulse : 0);
          check("data_rd_pulse", rd_cnt, mon_e.wr ? 0 : mon_e.pulse);
          check("data_drive_cycles", d_oe, mon_e.wr ? mon_e.phase : 0);
          if (mon_e.wr) check("data_byte", int'(d_byte), int'(mon_e.dato));
          check("dato_leido", int'(m_dl), int'(mon_e.rdata));
          check("latency", cyc, mon_e.lat);
          check("bus_rules", viol, 0);
          check("fin_outputs", int'({m_cs_n, m_oe, m_wr_n, m_rd_n, m_busy}), 'b10111);
          if (mon_e.gap != 0) check("done_gap", tick - last_done, mon_e.gap);
        end
        last_done = tick;
        trk = 1'b0;
      end
      p_wr   = m_wr_n;
      p_rd   = m_rd_n;
      p_ad   = m_ad;
      p_bo   = m_bus_out;
      p_busy = m_busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (m_busy && n < 100) begin step(); n++; end
    if (m_busy) begin
      errors++; checks++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 400) begin step(); n++; end
    if (n >= 400) begin
      errors++; checks++;
      $display("FAIL idle_timeout: %0d transactions outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_done(input int cnt);
    int seen = 0, n = 0;
    while (seen < cnt && n < 100 * cnt) begin
      step(); n++;
      if (m_done) seen++;
    end
    if (seen < cnt) begin
      errors++; checks++;
      $display("FAIL done_timeout: saw %0d done pulses, required %0d", seen, cnt);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] bi);
    wait_not_busy();
    rd_wr = w; dir = a; dato = d; bus_in = bi; start = 1'b1;
    push_exp(w, a, d, bi, 0);
    step();
    start = 1'b0;
    // Scramble operands mid-transaction; the latched copies must not follow.
    dir = 8'($urandom); dato = 8'($urandom); rd_wr = ~w;
  endtask

  task automatic held_start(input int n, input logic [7:0] a, input logic [7:0] bi);
    wait_idle();
    rd_wr = 1'b0; dir = a; dato = 8'h00; bus_in = bi;
    for (int k = 0; k < n; k++)
      push_exp(1'b0, a, 8'h00, bi, (k == 0) ? 0 : 2 * (sel ? S1 + P1 + H1 : S0 + P0 + H0) + 2);
    start = 1'b1;
    wait_done(n);
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1; start = 1'b0; rd_wr = 1'b0; sel = 1'b0;
    dir = 8'h00; dato = 8'h00; bus_in = 8'h00;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ctl0", int'({cs0, wr0, rd0, ad0, oe0, busy0, done0}), 'b1111000);
    check("reset_bus0", int'({bus_out0, dl0}), 0);
    check("reset_ctl1", int'({cs1, wr1, rd1, ad1, oe1, busy1, done1}), 'b1111000);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    issue(1'b1, 8'h21, 8'h45, 8'h00);
    issue(1'b0, 8'h43, 8'h00, 8'h59);
    wait_idle();

    // Starts during the strobes and during FIN must be ignored.
    issue(1'b1, 8'h3C, 8'h17, 8'h00);
    repeat (5) step();
    dir = 8'h99; dato = 8'h66; rd_wr = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1);
    dir = 8'h99; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();

    held_start(3, 8'h0B, 8'hA7);
    wait_idle();

    // Reset in the middle of the address strobe.
    rd_wr = 1'b1; dir = 8'h5A; dato = 8'h12; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (m_wr_n && n < 50) begin step(); n++; end
    check("reach_a_stb", int'(m_wr_n), 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ctl", int'({m_cs_n, m_wr_n, m_rd_n, m_oe, m_busy, m_done}), 'b111000);
    check("abort_bus", int'({m_bus_out, m_dl}), 0);
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    issue(1'b0, 8'h44, 8'h00, 8'h38);
    wait_idle();

    for (int i = 0; i < 10; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    wait_idle();
    repeat (2) step();

    sel = 1'b1;
    step();
    issue(1'b0, 8'h07, 8'h00, 8'h5E);
    issue(1'b1, 8'h08, 8'h31, 8'h00);
    for (int i = 0; i < 8; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    held_start(2, 8'h0C, 8'h23);
    wait_idle();
    repeat (3) step();

    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", dones, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
